staged_fifo: RTL and testbench
==============================

# staged_fifo

Circular-buffer FIFO with a write pointer, a read pointer, and NSTAGE ordered intermediate stage pointers between them. Entries enter at the head and leave at the tail. Before an entry can be read, each stage must advance past it in order. This is the synthesizable, parametrised successor of the four-pointer ordering property set: stage count, data width and depth are generic, and the block adds occupancy outputs and sticky error flags. It sits between a producer and a consumer where one or more in-order processing steps, such as commit or checksum, must see each entry first.

## Interface
- LGFIFO, 8: log2 of FIFO depth; depth = 2^LGFIFO entries.
- DW, 32: data word width.
- NSTAGE, 2: number of intermediate stage pointers, 1..8.
- i_clk  in  1  sole clock; all state changes on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_wr  in  1  write request.
- i_data  in  DW  write data.
- o_full  out  1  no free entry.
- i_adv  in  NSTAGE  bit s: stage s consumes its current entry.
- o_stage_valid  out  NSTAGE  bit s: stage s has an entry pending.
- o_stage_data  out  NSTAGE*DW  slice s: entry at stage pointer s.
- o_stage_fill  out  NSTAGE*(LGFIFO+1)  slice s: entries pending at stage s.
- i_rd  in  1  read request.
- o_data  out  DW  entry at tail.
- o_empty  out  1  no entry has passed the last stage.
- o_fill  out  LGFIFO+1  total entries held, head minus tail.
- o_overflow  out  1  sticky: write attempted while full.
- o_underflow  out  1  sticky: read while empty, or advance while stage invalid.

## Operation
- **Pointers**
  - head, p[0..NSTAGE-1] and tail are each LGFIFO+1 bits wide.
  - The memory index is the low LGFIFO bits. The MSB disambiguates full from empty.
  - Define p[-1] = head and p[NSTAGE] = tail.
- **Ordering invariant**: modulo 2^(LGFIFO+1), (p[s-1] - p[s]) summed over s = 0..NSTAGE equals head - tail, which is at most 2^LGFIFO.
- **Write**
  - Accepted when i_wr && !o_full.
  - Effect: mem[head] <= i_data, head <= head+1.
  - A rejected write sets o_overflow and has no other effect.
- **Stage s**
  - o_stage_valid[s] = (p[s-1] != p[s]).
  - o_stage_fill[s] = p[s-1] - p[s].
  - o_stage_data[s] = mem[p[s]], combinational read. It is undefined while the stage is invalid.
  - Advance occurs when i_adv[s] && o_stage_valid[s]: p[s] <= p[s]+1.
  - i_adv[s] while invalid sets o_underflow and leaves p[s] unchanged.
- **Read**
  - o_empty = (p[NSTAGE-1] == tail).
  - o_data = mem[tail].
  - Accepted when i_rd && !o_empty: tail <= tail+1.
  - i_rd while empty sets o_underflow.
- **Flags**
  - o_full = (head - tail == 2^LGFIFO).
  - o_fill = head - tail.
- **Simultaneous events**
  - All validity and full decisions use registered pointer values from the start of the cycle, so all ports may act in one cycle.
  - An entry written, or advanced by stage s-1, in cycle N becomes visible to the next consumer in cycle N+1.
  - A write is rejected when o_full, even if a read is accepted in the same cycle.
  - A read is refused when o_empty, even if the last stage advances in the same cycle.
- **Wrap-around**: all pointer arithmetic wraps modulo 2^(LGFIFO+1). The memory index wraps modulo 2^LGFIFO.
- **Reset**
  - Asserting i_reset_n low zeroes all pointers and both sticky flags immediately, mid-operation included.
  - Memory contents are not reset.
  - Release is synchronous to i_clk.

## Timing
- Reset values:
  - o_full=0, o_empty=1, o_stage_valid=0, o_fill=0, all o_stage_fill=0, o_overflow=0, o_underflow=0.
  - o_data and o_stage_data are undefined.
- Minimum latency from write to read-ready is NSTAGE+1 cycles, when every stage advances on its first valid cycle.
- Each stage and the read port can sustain one entry per cycle.
- All status outputs are combinational from registered pointers. There is no combinational path from any i_* request to any o_* output.
- The sticky flags update one cycle after the offending request.

## Test plan
- **Reset mid-flow**: with LGFIFO=2 and NSTAGE=2, write 3 entries, advance stage 0 once, then pulse i_reset_n low. Required: o_fill=0, o_empty=1 and o_stage_valid=00 before the next clock edge.
- **Ordered pipeline**: write 0xA1, 0xA2 back-to-back with i_adv=11 and i_rd=1 held throughout. Required: o_stage_data[0]=0xA1 in cycle 1, o_stage_data[1]=0xA1 in cycle 2, o_data=0xA1 with !o_empty in cycle 3, 0xA2 one cycle behind each.
- **Full**: with LGFIFO=2, write 4 entries and pass them through all stages. Required: o_full=1 and o_fill=4. A 5th write sets o_overflow. A simultaneous write and read while full gives o_fill=3 and leaves o_full=0 next cycle.
- **Stage blocking**: write 3 entries and hold i_adv[1]=0. Required: o_stage_fill[0] reaches 0, o_stage_fill[1]=3, o_empty stays 1. i_rd=1 sets o_underflow.
- **Wrap**: stream 20 entries with values 0..19 through a depth-4 FIFO with NSTAGE=2. Required: reads return 0..19 in order and neither sticky flag is set.
- **Invalid advance**: assert i_adv[0]=1 with the FIFO empty. Required: o_underflow=1 next cycle and all pointers unchanged.

Source files
------------

// File: rtl/staged_fifo.sv
// staged_fifo: circular-buffer FIFO with NSTAGE ordered stage pointers between
// the write head and the read tail. Every entry must be advanced past each
// stage, in order, before the read port can see it.
module staged_fifo #(
  parameter int LGFIFO = 8,
  parameter int DW     = 32,
  parameter int NSTAGE = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_wr,
  input  logic [DW-1:0]                i_data,
  output logic                         o_full,
  input  logic [NSTAGE-1:0]            i_adv,
  output logic [NSTAGE-1:0]            o_stage_valid,
  output logic [NSTAGE*DW-1:0]         o_stage_data,
  output logic [NSTAGE*(LGFIFO+1)-1:0] o_stage_fill,
  input  logic                         i_rd,
  output logic [DW-1:0]                o_data,
  output logic                         o_empty,
  output logic [LGFIFO:0]              o_fill,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  // Pointers carry one extra MSB so that head - tail distinguishes full from empty.
  localparam int              PW       = LGFIFO + 1;
  localparam int              DEPTH    = 2 ** LGFIFO;
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]   PTR_FULL = PW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW-1:0] stg_q  [NSTAGE];
  // up_ptr[s] is the pointer feeding stage s: head for stage 0, else stage s-1.
  logic [PW-1:0] up_ptr [NSTAGE];

  logic [NSTAGE-1:0] stage_valid;
  logic [NSTAGE-1:0] adv_ok;
  logic              wr_ok;
  logic              rd_ok;
  logic              adv_bad;
  logic [PW-1:0]     fill;

  // Per-stage status and combinational data view, all from registered pointers.
  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign up_ptr[g] = head_q;
    end else begin : g_rest
      assign up_ptr[g] = stg_q[g-1];
    end
    assign stage_valid[g]               = (up_ptr[g] != stg_q[g]);
    assign o_stage_fill[g*PW +: PW]     = up_ptr[g] - stg_q[g];
    assign o_stage_data[g*DW +: DW]     = mem[stg_q[g][LGFIFO-1:0]];
  end

  assign fill          = head_q - tail_q;
  assign o_fill        = fill;
  assign o_full        = (fill == PTR_FULL);
  assign o_empty       = (stg_q[NSTAGE-1] == tail_q);
  assign o_data        = mem[tail_q[LGFIFO-1:0]];
  assign o_stage_valid = stage_valid;

  // Accept/refuse decisions for every port, taken from start-of-cycle pointers.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_ok   = 1'b0;
    rd_ok   = 1'b0;
    adv_ok  = '0;
    adv_bad = 1'b0;
    wr_ok   = i_wr && !o_full;
    rd_ok   = i_rd && !o_empty;
    for (int s = 0; s < NSTAGE; s++) begin
      adv_ok[s] = i_adv[s] && stage_valid[s];
      if (i_adv[s] && !stage_valid[s]) begin
        adv_bad = 1'b1;
      end
    end
  end

  // Pointer advance; reset zeroes every pointer at once, mid-operation included.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: state registers use non-blocking assignments so every pointer sees
    // the other pointers' start-of-cycle values regardless of statement order.
    if (!i_reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int s = 0; s < NSTAGE; s++) begin
        stg_q[s] <= '0;
      end
    end else begin
      if (wr_ok) begin
        head_q <= head_q + PTR_ONE;
      end
      if (rd_ok) begin
        tail_q <= tail_q + PTR_ONE;
      end
      for (int s = 0; s < NSTAGE; s++) begin
        if (adv_ok[s]) begin
          stg_q[s] <= stg_q[s] + PTR_ONE;
        end
      end
    end
  end

  // Sticky error flags: set by a refused request, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr && o_full) begin
        o_overflow <= 1'b1;
      end
      if ((i_rd && o_empty) || adv_bad) begin
        o_underflow <= 1'b1;
      end
    end
  end

  // Storage write at the head.
  always_ff @(posedge i_clk) begin
    // NOTE: the array has no reset; only the pointers define which entries
    // are meaningful, and a reset port would prevent RAM inference.
    if (wr_ok) begin
      mem[head_q[LGFIFO-1:0]] <= i_data;
    end
  end

endmodule

// File: tb/tb_staged_fifo.sv
// Directed bench for staged_fifo with LGFIFO=2 (depth 4), DW=8, NSTAGE=2.
module tb_staged_fifo;

  localparam int LGFIFO = 2;
  localparam int DW     = 8;
  localparam int NSTAGE = 2;
  localparam int PW     = LGFIFO + 1;

  logic                   i_clk;
  logic                   i_reset_n;
  logic                   i_wr;
  logic [DW-1:0]          i_data;
  logic                   o_full;
  logic [NSTAGE-1:0]      i_adv;
  logic [NSTAGE-1:0]      o_stage_valid;
  logic [NSTAGE*DW-1:0]   o_stage_data;
  logic [NSTAGE*PW-1:0]   o_stage_fill;
  logic                   i_rd;
  logic [DW-1:0]          o_data;
  logic                   o_empty;
  logic [LGFIFO:0]        o_fill;
  logic                   o_overflow;
  logic                   o_underflow;

  int checks   = 0;
  int failures = 0;

  staged_fifo #(.LGFIFO(LGFIFO), .DW(DW), .NSTAGE(NSTAGE)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_wr          (i_wr),
    .i_data        (i_data),
    .o_full        (o_full),
    .i_adv         (i_adv),
    .o_stage_valid (o_stage_valid),
    .o_stage_data  (o_stage_data),
    .o_stage_fill  (o_stage_fill),
    .i_rd          (i_rd),
    .o_data        (o_data),
    .o_empty       (o_empty),
    .o_fill        (o_fill),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Short reset pulse placed away from the clock edge.
  task automatic pulse_reset();
    i_wr = 1'b0; i_rd = 1'b0; i_adv = '0;
    i_reset_n = 1'b0;
    #2;
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_wr      = 1'b0;
    i_rd      = 1'b0;
    i_adv     = '0;
    i_data    = '0;
    #3;

    // Reset state.
    check("rst_fill",      32'(o_fill),        32'd0);
    check("rst_empty",     32'(o_empty),       32'd1);
    check("rst_full",      32'(o_full),        32'd0);
    check("rst_svalid",    32'(o_stage_valid), 32'd0);
    check("rst_sfill",     32'(o_stage_fill),  32'd0);
    check("rst_overflow",  32'(o_overflow),    32'd0);
    check("rst_underflow", 32'(o_underflow),   32'd0);
    i_reset_n = 1'b1;
    step();

    // Ordered pipeline: A1 then A2, adv=11 and rd=1 held throughout.
    i_adv = 2'b11; i_rd = 1'b1;
    i_wr = 1'b1; i_data = 8'hA1;
    step();                                        // cycle 1
    check("pipe_c1_sv0",  32'(o_stage_valid[0]),  32'd1);
    check("pipe_c1_sd0",  32'(o_stage_data[7:0]), 32'hA1);
    i_data = 8'hA2;
    step();                                        // cycle 2
    i_wr = 1'b0;
    check("pipe_c2_sd1",  32'(o_stage_data[15:8]), 32'hA1);
    check("pipe_c2_sd0",  32'(o_stage_data[7:0]),  32'hA2);
    check("pipe_c2_empty", 32'(o_empty),           32'd1);
    step();                                        // cycle 3
    check("pipe_c3_data",  32'(o_data),             32'hA1);
    check("pipe_c3_empty", 32'(o_empty),            32'd0);
    check("pipe_c3_sd1",   32'(o_stage_data[15:8]), 32'hA2);
    step();                                        // cycle 4
    check("pipe_c4_data",  32'(o_data),  32'hA2);
    check("pipe_c4_empty", 32'(o_empty), 32'd0);
    step();                                        // cycle 5
    i_adv = '0; i_rd = 1'b0;
    check("pipe_c5_empty", 32'(o_empty),     32'd1);
    check("pipe_c5_fill",  32'(o_fill),      32'd0);
    // The read and stage-1 advance in cycle 0 were refused.
    check("pipe_underflow", 32'(o_underflow), 32'd1);
    check("pipe_overflow",  32'(o_overflow),  32'd0);

    // Reset mid-flow: 3 writes, one stage-0 advance, then async reset.
    pulse_reset();
    check("rst2_underflow", 32'(o_underflow), 32'd0);
    step();
    i_wr = 1'b1;
    i_data = 8'h01; step();
    i_data = 8'h02; step();
    i_data = 8'h03; step();
    i_wr = 1'b0; i_adv = 2'b01;
    step();
    i_adv = '0;
    check("mid_fill",  32'(o_fill),            32'd3);
    check("mid_sf0",   32'(o_stage_fill[2:0]), 32'd2);
    check("mid_sf1",   32'(o_stage_fill[5:3]), 32'd1);
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_fill",  32'(o_fill),        32'd0);
    check("mid_rst_empty", 32'(o_empty),       32'd1);
    check("mid_rst_sv",    32'(o_stage_valid), 32'd0);
    check("mid_rst_sf",    32'(o_stage_fill),  32'd0);
    #1;
    i_reset_n = 1'b1;
    step();

    // Full: 4 writes, pushed through both stages.
    i_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data = 8'(8'h10 + k);
      step();
    end
    i_wr = 1'b0;
    check("full_sf0", 32'(o_stage_fill[2:0]), 32'd4);
    i_adv = 2'b01;
    for (int k = 0; k < 4; k++) step();
    i_adv = 2'b10;
    for (int k = 0; k < 4; k++) step();
    i_adv = '0;
    check("full_full",      32'(o_full),      32'd1);
    check("full_fill",      32'(o_fill),      32'd4);
    check("full_empty",     32'(o_empty),     32'd0);
    check("full_data",      32'(o_data),      32'h10);
    check("full_underflow", 32'(o_underflow), 32'd0);
    check("full_overflow0", 32'(o_overflow),  32'd0);
    i_wr = 1'b1; i_data = 8'h55;
    step();
    i_wr = 1'b0;
    check("full_overflow1", 32'(o_overflow), 32'd1);
    check("full_fill_kept", 32'(o_fill),     32'd4);
    i_wr = 1'b1; i_rd = 1'b1; i_data = 8'h66;
    step();
    i_wr = 1'b0; i_rd = 1'b0;
    check("full_wr_rd_fill", 32'(o_fill), 32'd3);
    check("full_wr_rd_full", 32'(o_full), 32'd0);
    check("full_wr_rd_data", 32'(o_data), 32'h11);

    // Stage blocking: stage 1 held, stage 0 drains.
    pulse_reset();
    step();
    i_wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = 8'(8'h20 + k);
      step();
    end
    i_wr = 1'b0; i_adv = 2'b01;
    for (int k = 0; k < 3; k++) step();
    i_adv = '0;
    check("blk_sf0",       32'(o_stage_fill[2:0]),  32'd0);
    check("blk_sf1",       32'(o_stage_fill[5:3]),  32'd3);
    check("blk_sv",        32'(o_stage_valid),      32'b10);
    check("blk_sd1",       32'(o_stage_data[15:8]), 32'h20);
    check("blk_empty",     32'(o_empty),            32'd1);
    check("blk_underflow0", 32'(o_underflow),       32'd0);
    i_rd = 1'b1;
    step();
    i_rd = 1'b0;
    check("blk_underflow1", 32'(o_underflow), 32'd1);
    check("blk_fill",       32'(o_fill),      32'd3);
    check("blk_empty2",     32'(o_empty),     32'd1);

    // Wrap: 20 entries through the depth-4 FIFO.
    pulse_reset();
    step();
    for (int v = 0; v < 20; v++) begin
      i_wr = 1'b1; i_data = 8'(v);
      step();
      i_wr = 1'b0; i_adv = 2'b01;
      step();
      i_adv = 2'b10;
      step();
      i_adv = '0;
      check("wrap_data", 32'(o_data), 32'(v));
      i_rd = 1'b1;
      step();
      i_rd = 1'b0;
    end
    check("wrap_empty",     32'(o_empty),     32'd1);
    check("wrap_fill",      32'(o_fill),      32'd0);
    check("wrap_overflow",  32'(o_overflow),  32'd0);
    check("wrap_underflow", 32'(o_underflow), 32'd0);

    // Invalid advance with the FIFO empty.
    pulse_reset();
    step();
    i_adv = 2'b01;
    step();
    i_adv = '0;
    check("inv_underflow", 32'(o_underflow),   32'd1);
    check("inv_sv",        32'(o_stage_valid), 32'd0);
    check("inv_fill",      32'(o_fill),        32'd0);
    check("inv_empty",     32'(o_empty),       32'd1);
    // Stage 0 pointer must still sit on the head: one write gives fill 1 there.
    i_wr = 1'b1; i_data = 8'h77;
    step();
    i_wr = 1'b0;
    check("inv_sf0", 32'(o_stage_fill[2:0]),  32'd1);
    check("inv_sd0", 32'(o_stage_data[7:0]),  32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
